microprocessor_system_top: RTL and testbench

- Self-contained 32-bit multi-cycle CPU with word-organised internal memory; top-level processor block of the system.
- Executes a program preloaded into `internal_memory`, forwards out-of-range data accesses to an external bus, and stops on HLT.
- Testbenches check results by reading `internal_memory` hierarchically and watching `system_halted`.

---
 rtl/microprocessor_system_top_if.sv | 26 ++
 rtl/microprocessor_system_top.sv | 225 ++++++++++++++++++++++
 tb/tb_microprocessor_system_top.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/microprocessor_system_top_if.sv
// External data-bus interface of the CPU, seen from the bus side.
// The CPU raises ext_mem_enable together with exactly one of
// ext_mem_read/ext_mem_write and holds ext_addr (and write data) stable
// until a rising clock edge samples ext_mem_ready=1; that edge completes the
// transfer and the strobes drop on the following cycle.
// Read data is returned on the tristate ext_data bus through slave_data /
// slave_drive.
interface microprocessor_system_top_if;
  logic [31:0] ext_addr;
  logic        ext_mem_read;
  logic        ext_mem_write;
  logic        ext_mem_enable;
  logic        ext_mem_ready;
  logic [31:0] slave_data;
  logic        slave_drive;

  modport master (
    output ext_addr, ext_mem_read, ext_mem_write, ext_mem_enable,
    input  ext_mem_ready, slave_data, slave_drive
  );

  modport slave (
    input  ext_addr, ext_mem_read, ext_mem_write, ext_mem_enable,
    output ext_mem_ready, slave_data, slave_drive
  );
endinterface

// File: rtl/microprocessor_system_top.sv
// 32-bit multi-cycle CPU: FETCH -> EXEC -> (MEM) -> FETCH, HALT on HLT.
// Instructions always come from internal_memory; data accesses beyond the
// internal range go to the external bus.
// External bus: enable plus one strobe held with a stable address/data until
// a rising edge sees ext_mem_ready=1; strobes drop on the next cycle.
module microprocessor_system_top #(
  parameter int          MEM_WORDS = 16384,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ext_addr,
  inout  wire  [31:0] ext_data,
  output logic        ext_mem_read,
  output logic        ext_mem_write,
  output logic        ext_mem_enable,
  input  logic        ext_mem_ready,
  output logic [7:0]  io_addr,
  inout  wire  [7:0]  io_data,
  output logic        io_read,
  output logic        io_write,
  input  logic [7:0]  external_interrupts,
  output logic        system_halted,
  output logic [31:0] pc_out,
  output logic [7:0]  cpu_flags
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  localparam logic [5:0] OP_ADD  = 6'h01, OP_SUB = 6'h02, OP_AND = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04, OP_XOR = 6'h05, OP_SHL = 6'h06;
  localparam logic [5:0] OP_SHR  = 6'h07, OP_ADDI = 6'h08, OP_LUI = 6'h09;
  localparam logic [5:0] OP_ORI  = 6'h0A, OP_LW  = 6'h0B, OP_SW  = 6'h0C;
  localparam logic [5:0] OP_CMP  = 6'h0D, OP_JMP = 6'h0E, OP_JZ  = 6'h0F;
  localparam logic [5:0] OP_JNZ  = 6'h10, OP_JC  = 6'h11, OP_JNC = 6'h12;
  localparam logic [5:0] OP_JN   = 6'h13, OP_HLT = 6'h3F;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_e;

  // Program/data store, preloaded from outside and never cleared by reset.
  reg [31:0] internal_memory [0:MEM_WORDS-1];

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  flags_q, flags_d;          // {V, N, Z, C}
  logic [31:0] regs_q [32];

  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        mem_we;

  // Instruction fields.
  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] sext, zext, rs1v, rs2v, rdv;
  assign op   = ir_q[31:26];
  assign rd   = ir_q[25:21];
  assign rs1  = ir_q[20:16];
  assign rs2  = ir_q[15:11];
  assign sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext = {16'h0000, ir_q[15:0]};
  assign rs1v = regs_q[rs1];
  assign rs2v = regs_q[rs2];
  assign rdv  = regs_q[rd];

  // Shared adder/subtractor and flag helpers.
  logic [31:0] add_b, jmp_tgt;
  logic [32:0] add_r, sub_r;
  logic        add_v, sub_v, mem_int, is_sw, ext_active;
  assign add_b   = (op == OP_ADD) ? rs2v : sext;
  assign add_r   = {1'b0, rs1v} + {1'b0, add_b};
  assign sub_r   = {1'b0, rs1v} - {1'b0, rs2v};
  assign add_v   = (rs1v[31] == add_b[31]) && (add_r[31] != rs1v[31]);
  assign sub_v   = (rs1v[31] != rs2v[31]) && (sub_r[31] != rs1v[31]);
  assign jmp_tgt = pc_q + 32'd4 + {sext[29:0], 2'b00};
  assign mem_int = ({1'b0, addr_q} < MEM_BYTES);
  assign is_sw   = (op == OP_SW);
  assign ext_active = (state_q == MEM) && !mem_int;

  // Next-state, datapath and writeback control.
  always_comb begin
    logic [31:0] lres;
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    flags_d  = flags_q;
    rf_we    = 1'b0;
    rf_wdata = 32'h0;
    mem_we   = 1'b0;
    lres     = 32'h0;
    case (state_q)
      FETCH: begin
        ir_d    = internal_memory[pc_q[AW+1:2]];
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + 32'd4;
        case (op)
          OP_ADD, OP_ADDI: begin
            rf_we    = 1'b1;
            rf_wdata = add_r[31:0];
            flags_d  = {add_v, add_r[31], add_r[31:0] == 32'h0, add_r[32]};
          end
          OP_SUB, OP_CMP: begin
            rf_we    = (op == OP_SUB);
            rf_wdata = sub_r[31:0];
            flags_d  = {sub_v, sub_r[31], sub_r[31:0] == 32'h0, sub_r[32]};
          end
          OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ORI: begin
            case (op)
              OP_AND:  lres = rs1v & rs2v;
              OP_OR:   lres = rs1v | rs2v;
              OP_XOR:  lres = rs1v ^ rs2v;
              OP_SHL:  lres = rs1v << rs2v[4:0];
              OP_SHR:  lres = rs1v >> rs2v[4:0];
              default: lres = rs1v | zext;
            endcase
            rf_we    = 1'b1;
            rf_wdata = lres;
            flags_d  = {1'b0, lres[31], lres == 32'h0, 1'b0};
          end
          OP_LUI: begin
            rf_we    = 1'b1;
            rf_wdata = {ir_q[15:0], 16'h0000};
          end
          OP_LW, OP_SW: begin
            addr_d  = add_r[31:0];
            wdata_d = rdv;
            state_d = MEM;
          end
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (flags_q[1])  pc_d = jmp_tgt;
          OP_JNZ: if (!flags_q[1]) pc_d = jmp_tgt;
          OP_JC:  if (flags_q[0])  pc_d = jmp_tgt;
          OP_JNC: if (!flags_q[0]) pc_d = jmp_tgt;
          OP_JN:  if (flags_q[2])  pc_d = jmp_tgt;
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
          default: ;
        endcase
      end
      MEM: begin
        if (mem_int) begin
          if (is_sw) begin
            mem_we = 1'b1;
          end else begin
            rf_we    = 1'b1;
            rf_wdata = internal_memory[addr_q[AW+1:2]];
          end
          state_d = FETCH;
        end else if (ext_mem_ready) begin
          if (!is_sw) begin
            rf_we    = 1'b1;
            rf_wdata = ext_data;
          end
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      flags_q <= 4'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      flags_q <= flags_d;
    end
  end

  // Register file; r0 stays zero because writes to it are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (rf_we && (rd != 5'd0)) begin
      regs_q[rd] <= rf_wdata;
    end
  end

  // Internal data writes; no reset so contents survive a reset pulse.
  always @(posedge clk) begin
    if (mem_we) internal_memory[addr_q[AW+1:2]] <= wdata_q;
  end

  // External bus outputs follow the state register, so reset drops them at once.
  assign ext_mem_enable = ext_active;
  assign ext_mem_write  = ext_active && is_sw;
  assign ext_mem_read   = ext_active && !is_sw;
  assign ext_addr       = ext_active ? addr_q : 32'h0;
  assign ext_data       = (ext_active && is_sw) ? wdata_q : 32'hzzzz_zzzz;

  // I/O port is unused by this core.
  assign io_addr  = 8'h00;
  assign io_data  = 8'hzz;
  assign io_read  = 1'b0;
  assign io_write = 1'b0;

  assign system_halted = (state_q == HALT);
  assign pc_out        = pc_q;
  assign cpu_flags     = {4'b0000, flags_q};

  logic unused_inputs;
  assign unused_inputs = ^external_interrupts;

endmodule

// File: tb/tb_microprocessor_system_top.sv
// Directed bench for microprocessor_system_top: small hand-assembled programs
// are loaded into internal_memory during reset and results are compared with
// hand-computed values.
module tb_microprocessor_system_top;

  localparam logic [5:0] ADD = 6'h01, SUB = 6'h02, AND_ = 6'h03, OR_ = 6'h04;
  localparam logic [5:0] XOR_ = 6'h05, SHL = 6'h06, SHR = 6'h07, ADDI = 6'h08;
  localparam logic [5:0] LUI = 6'h09, ORI = 6'h0A, LW = 6'h0B, SW = 6'h0C;
  localparam logic [5:0] CMP = 6'h0D, JMP = 6'h0E, JZ = 6'h0F, JNZ = 6'h10;
  localparam logic [5:0] JNC = 6'h12, JN = 6'h13, HLT = 6'h3F;

  logic        clk;
  logic        rst_n;
  wire  [31:0] ext_data_w;
  wire  [7:0]  io_data_w;
  logic [7:0]  io_addr_w;
  logic        io_read_w, io_write_w, system_halted;
  logic [31:0] pc_out;
  logic [7:0]  cpu_flags;
  logic [7:0]  irq;

  int checks = 0;
  int errors = 0;
  int wp     = 0;
  int ncyc;
  logic [31:0] ext_word;

  microprocessor_system_top_if bus ();
  assign ext_data_w = bus.slave_drive ? bus.slave_data : 32'hzzzz_zzzz;

  microprocessor_system_top dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ext_addr            (bus.ext_addr),
    .ext_data            (ext_data_w),
    .ext_mem_read        (bus.ext_mem_read),
    .ext_mem_write       (bus.ext_mem_write),
    .ext_mem_enable      (bus.ext_mem_enable),
    .ext_mem_ready       (bus.ext_mem_ready),
    .io_addr             (io_addr_w),
    .io_data             (io_data_w),
    .io_read             (io_read_w),
    .io_write            (io_write_w),
    .external_interrupts (irq),
    .system_halted       (system_halted),
    .pc_out              (pc_out),
    .cpu_flags           (cpu_flags)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic logic [31:0] er(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic begin_load();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ext_mem_ready = 1'b0;
    bus.slave_drive   = 1'b0;
    for (int i = 0; i < 16384; i++) dut.internal_memory[i] = 32'h0;
    wp = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    dut.internal_memory[wp] = w;
    wp++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_halt(input string tag, input int budget, output int n);
    n = 0;
    while (system_halted !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {31'b0, system_halted}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    irq = 8'hA5;
    bus.ext_mem_ready = 1'b0;
    bus.slave_drive   = 1'b0;
    bus.slave_data    = 32'h0;
    ext_word = 32'h0;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_halted", {31'b0, system_halted}, 32'd0);
    chk("rst_flags", {24'b0, cpu_flags}, 32'h0);
    chk("rst_enable", {31'b0, bus.ext_mem_enable}, 32'd0);
    chk("rst_addr", bus.ext_addr, 32'h0);
    chk("rst_io", {22'b0, io_addr_w, io_read_w, io_write_w}, 32'h0);

    // Arithmetic: 5 + 7 stored at 0x2000.
    begin_load();
    emit(ei(ADDI, 1, 0, 16'd5));
    emit(ei(ADDI, 2, 0, 16'd7));
    emit(er(ADD, 3, 1, 2));
    emit(ei(SW, 3, 0, 16'h2000));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    run_to_halt("arith_halt", 200, ncyc);
    chk("arith_cycles", ncyc, 32'd11);
    chk("arith_mem", dut.internal_memory['h800], 32'd12);
    chk("arith_pc", pc_out, 32'h10);
    step(3);
    chk("arith_pc_hold", pc_out, 32'h10);

    // Flags: -1 then +1 gives Z and C.
    begin_load();
    emit(ei(ADDI, 1, 0, 16'hFFFF));
    emit(ei(ADDI, 1, 1, 16'd1));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    step(2);
    chk("flags_neg", {24'b0, cpu_flags}, 32'h04);
    run_to_halt("flags_halt", 200, ncyc);
    chk("flags_zc", {24'b0, cpu_flags}, 32'h03);

    // CMP borrow/negative, JN taken, JNC not taken.
    begin_load();
    emit(ei(ADDI, 1, 0, 16'd1));
    emit(er(CMP, 0, 0, 1));
    emit(ei(JN, 0, 0, 16'd1));
    emit(ei(ADDI, 5, 0, 16'd1));
    emit(ei(JNC, 0, 0, 16'd1));
    emit(ei(SW, 1, 0, 16'h2000));
    emit(ei(SW, 5, 0, 16'h2004));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    run_to_halt("cmp_halt", 200, ncyc);
    chk("cmp_flags", {24'b0, cpu_flags}, 32'h05);
    chk("cmp_jnc_fall", dut.internal_memory['h800], 32'd1);
    chk("cmp_jn_skip", dut.internal_memory['h801], 32'd0);

    // Overflow, LUI keeps flags, OR clears V/C.
    begin_load();
    emit(ei(LUI, 4, 0, 16'h7FFF));
    emit(ei(ORI, 4, 4, 16'hFFFF));
    emit(ei(ADDI, 5, 4, 16'd1));
    emit(ei(LUI, 2, 0, 16'h8000));
    emit(er(OR_, 3, 2, 0));
    emit(ei(SW, 5, 0, 16'h2000));
    emit(ei(SW, 3, 0, 16'h2004));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    step(6);
    chk("ovf_flags", {24'b0, cpu_flags}, 32'h0C);
    step(2);
    chk("lui_keeps_flags", {24'b0, cpu_flags}, 32'h0C);
    run_to_halt("ovf_halt", 200, ncyc);
    chk("or_flags", {24'b0, cpu_flags}, 32'h04);
    chk("ovf_sum", dut.internal_memory['h800], 32'h8000_0000);
    chk("lui_val", dut.internal_memory['h801], 32'h8000_0000);

    // Shifts and logic, SUB with borrow.
    begin_load();
    emit(ei(ADDI, 1, 0, 16'h00F0));
    emit(ei(ADDI, 2, 0, 16'd4));
    emit(er(SHL, 3, 1, 2));
    emit(er(SHR, 4, 1, 2));
    emit(er(XOR_, 5, 3, 1));
    emit(er(AND_, 6, 5, 1));
    emit(er(SUB, 7, 4, 1));
    emit(ei(SW, 3, 0, 16'h2000));
    emit(ei(SW, 4, 0, 16'h2004));
    emit(ei(SW, 5, 0, 16'h2008));
    emit(ei(SW, 6, 0, 16'h200C));
    emit(ei(SW, 7, 0, 16'h2010));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    run_to_halt("logic_halt", 300, ncyc);
    chk("shl", dut.internal_memory['h800], 32'h0000_0F00);
    chk("shr", dut.internal_memory['h801], 32'h0000_000F);
    chk("xor", dut.internal_memory['h802], 32'h0000_0FF0);
    chk("and", dut.internal_memory['h803], 32'h0000_00F0);
    chk("sub", dut.internal_memory['h804], 32'hFFFF_FF1F);
    chk("sub_flags", {24'b0, cpu_flags}, 32'h05);

    // Backward JNZ loop, JZ and JMP skips.
    begin_load();
    emit(ei(ADDI, 1, 0, 16'd3));
    emit(ei(ADDI, 2, 0, 16'd0));
    emit(ei(ADDI, 2, 2, 16'd1));
    emit(ei(ADDI, 1, 1, 16'hFFFF));
    emit(ei(JNZ, 0, 0, 16'hFFFD));
    emit(ei(JZ, 0, 0, 16'd1));
    emit(ei(ADDI, 2, 2, 16'd100));
    emit(ei(JMP, 0, 0, 16'd1));
    emit(ei(ADDI, 2, 2, 16'd100));
    emit(ei(SW, 1, 0, 16'h2000));
    emit(ei(SW, 2, 0, 16'h2004));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    run_to_halt("loop_halt", 500, ncyc);
    chk("loop_r1", dut.internal_memory['h800], 32'd0);
    chk("loop_count", dut.internal_memory['h801], 32'd3);
    chk("loop_pc", pc_out, 32'h2C);

    // Bubble sort of four words at 0x1000.
    begin_load();
    dut.internal_memory['h400] = 32'd50000;
    dut.internal_memory['h401] = 32'd10000;
    dut.internal_memory['h402] = 32'd80000;
    dut.internal_memory['h403] = 32'd30000;
    emit(ei(ADDI, 10, 0, 16'd3));
    emit(ei(ADDI, 11, 0, 16'h1000));
    emit(ei(ADDI, 12, 0, 16'd3));
    emit(ei(LW, 1, 11, 16'd0));
    emit(ei(LW, 2, 11, 16'd4));
    emit(er(CMP, 0, 2, 1));
    emit(ei(JNC, 0, 0, 16'd2));
    emit(ei(SW, 2, 11, 16'd0));
    emit(ei(SW, 1, 11, 16'd4));
    emit(ei(ADDI, 11, 11, 16'd4));
    emit(ei(ADDI, 12, 12, 16'hFFFF));
    emit(ei(JNZ, 0, 0, 16'hFFF7));
    emit(ei(ADDI, 10, 10, 16'hFFFF));
    emit(ei(JNZ, 0, 0, 16'hFFF3));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    run_to_halt("sort_halt", 10000, ncyc);
    chk("sort0", dut.internal_memory['h400], 32'd10000);
    chk("sort1", dut.internal_memory['h401], 32'd30000);
    chk("sort2", dut.internal_memory['h402], 32'd50000);
    chk("sort3", dut.internal_memory['h403], 32'd80000);
    chk("sort_pc", pc_out, 32'h38);

    // External write with a 3-cycle wait, then external read back.
    begin_load();
    emit(ei(LUI, 1, 0, 16'h0001));
    emit(ei(LUI, 2, 0, 16'hCAFE));
    emit(ei(ORI, 2, 2, 16'h0123));
    emit(ei(SW, 2, 1, 16'h0000));
    emit(ei(LW, 3, 1, 16'h0000));
    emit(ei(SW, 3, 0, 16'h2000));
    emit(ei(HLT, 0, 0, 16'h0));
    release_reset();
    step(8);
    for (int w = 0; w < 3; w++) begin
      chk("ext_wr_enable", {31'b0, bus.ext_mem_enable}, 32'd1);
      chk("ext_wr_strobe", {30'b0, bus.ext_mem_write, bus.ext_mem_read}, 32'd2);
      chk("ext_wr_addr", bus.ext_addr, 32'h0001_0000);
      chk("ext_wr_data", ext_data_w, 32'hCAFE_0123);
      if (w < 2) step(1);
    end
    ext_word = ext_data_w;
    bus.ext_mem_ready = 1'b1;
    step(1);
    bus.ext_mem_ready = 1'b0;
    chk("ext_wr_release", {29'b0, bus.ext_mem_enable, bus.ext_mem_write, bus.ext_mem_read}, 32'd0);
    step(2);
    chk("ext_rd_strobe", {29'b0, bus.ext_mem_enable, bus.ext_mem_write, bus.ext_mem_read}, 32'd5);
    chk("ext_rd_addr", bus.ext_addr, 32'h0001_0000);
    bus.slave_data    = ext_word;
    bus.slave_drive   = 1'b1;
    bus.ext_mem_ready = 1'b1;
    step(1);
    bus.slave_drive   = 1'b0;
    bus.ext_mem_ready = 1'b0;
    chk("ext_rd_release", {29'b0, bus.ext_mem_enable, bus.ext_mem_write, bus.ext_mem_read}, 32'd0);
    run_to_halt("ext_halt", 200, ncyc);
    chk("ext_rd_data", dut.internal_memory['h800], 32'hCAFE_0123);

    // Asynchronous reset in the middle of a stalled external write.
    begin_load();
    dut.internal_memory['h900] = 32'hA5A5_5A5A;
    emit(ei(ADDI, 1, 0, 16'h0055));
    emit(ei(SW, 1, 0, 16'h2000));
    emit(ei(LUI, 2, 0, 16'h0001));
    emit(ei(SW, 1, 2, 16'h0000));
    release_reset();
    step(9);
    chk("mid_enable", {29'b0, bus.ext_mem_enable, bus.ext_mem_write, bus.ext_mem_read}, 32'd6);
    chk("mid_pc", pc_out, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_strobes", {29'b0, bus.ext_mem_enable, bus.ext_mem_write, bus.ext_mem_read}, 32'd0);
    chk("async_addr", bus.ext_addr, 32'h0);
    chk("async_pc", pc_out, 32'h0);
    chk("async_halted", {31'b0, system_halted}, 32'd0);
    chk("async_flags", {24'b0, cpu_flags}, 32'h0);
    step(2);
    chk("keep_written", dut.internal_memory['h800], 32'h55);
    chk("keep_preload", dut.internal_memory['h900], 32'hA5A5_5A5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
